// File: rtl/axis_tx_pkg.sv
// axis_tx_pkg: shared state encoding, mode constants and clog2 helper for axis_frame_tx.
package axis_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/frame_word_sel.sv
// frame_word_sel: payload register bank captured at frame start, with a word mux on the selected index.
module frame_word_sel #(
    parameter int DATA_W  = 16,
    parameter int N_WORDS = 3,
    parameter int SEL_W   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_load,
    input  logic [N_WORDS*DATA_W-1:0]   i_payload,
    input  logic [SEL_W-1:0]            i_sel,
    output logic [DATA_W-1:0]           o_word
);

    logic [N_WORDS*DATA_W-1:0] r_bank;

    always_ff @(posedge clk) begin
        if (!reset_n) r_bank <= '0;
        else if (i_load) r_bank <= i_payload;
    end

    always_comb begin
        o_word = '0;
        for (int i = 0; i < N_WORDS; i++)
            if (i_sel == SEL_W'(i)) o_word = r_bank[i*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/axis_frame_tx.sv
// axis_frame_tx: AXI4-Stream frame transmitter with clamped length, partial final keep,
// one-shot/continuous modes, optional inter-frame gap and a completed-frame counter.
module axis_frame_tx
    import axis_tx_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int N_WORDS    = 3,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16,
    localparam int KEEP_W    = DATA_W / 8,
    localparam int LEN_W     = clog2(N_WORDS + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        mode,
    input  logic [LEN_W-1:0]            frame_len,
    input  logic [KEEP_W-1:0]           last_keep,
    input  logic [N_WORDS*DATA_W-1:0]   payload,
    output logic [DATA_W-1:0]           m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast,
    output logic [KEEP_W-1:0]           m_tkeep,
    output logic                        busy,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            frame_cnt
);

    localparam logic [LEN_W-1:0] NW       = LEN_W'(N_WORDS);
    localparam int               GW       = GAP_CYCLES > 1 ? clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t              r_state;
    logic                r_busy, r_tvalid, r_tlast, r_done, r_mode;
    logic [DATA_W-1:0]   r_tdata;
    logic [KEEP_W-1:0]   r_tkeep, r_keep;
    logic [CNT_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_idx, r_len;
    logic [GW-1:0]       r_gap;

    logic                w_xfer, w_cap, w_nlast;
    logic [LEN_W-1:0]    w_len, w_nidx;
    logic [KEEP_W-1:0]   w_keep;
    logic [DATA_W-1:0]   w_word;

    assign w_xfer  = r_tvalid & m_tready;
    assign w_len   = (frame_len == '0 || frame_len > NW) ? NW : frame_len;
    assign w_keep  = (last_keep == '0) ? '1 : last_keep;
    assign w_nidx  = r_idx + 1'b1;
    assign w_nlast = (w_nidx == r_len - 1'b1);
    // Capture points: idle start, end of gap, and back-to-back restart on the final beat.
    assign w_cap   = en && (r_state == IDLE || (r_state == GAP && r_gap == GAP_LAST) ||
                            (w_xfer && r_tlast && r_mode == MODE_CONT && GAP_CYCLES == 0));

    frame_word_sel #(
        .DATA_W  (DATA_W),
        .N_WORDS (N_WORDS),
        .SEL_W   (LEN_W)
    ) u_sel (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_cap),
        .i_payload (payload),
        .i_sel     (w_nidx),
        .o_word    (w_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tkeep  <= '0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_keep   <= '0;
            r_mode   <= MODE_ONESHOT;
            r_gap    <= '0;
        end else begin
            r_done <= w_xfer && r_tlast;
            if (w_xfer && r_tlast) r_cnt <= r_cnt + 1'b1;
            if (w_cap) begin
                r_len    <= w_len;
                r_keep   <= w_keep;
                r_mode   <= mode;
                r_idx    <= '0;
                r_tdata  <= payload[DATA_W-1:0];
                r_tvalid <= 1'b1;
                r_tlast  <= (w_len == LEN_W'(1));
                r_tkeep  <= (w_len == LEN_W'(1)) ? w_keep : '1;
                r_state  <= SEND;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    SEND: if (w_xfer) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tdata  <= '0;
                            r_tlast  <= 1'b0;
                            r_tkeep  <= '0;
                            r_gap    <= '0;
                            r_state  <= !en ? IDLE : (r_mode == MODE_CONT ? GAP : HOLD);
                            r_busy   <= en;
                        end else begin
                            r_idx   <= w_nidx;
                            r_tdata <= w_word;
                            r_tlast <= w_nlast;
                            r_tkeep <= w_nlast ? r_keep : '1;
                        end
                    end
                    GAP: if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                    HOLD: if (!en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign m_tkeep    = r_tkeep;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_axis_frame_tx.sv
// tb_axis_frame_tx: table-driven cycle vectors plus directed multi-cycle sequences
// for a back-to-back instance and a GAP_CYCLES=2 instance sharing the same stimulus.
module tb_axis_frame_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  frame_len = 2'd3;
    logic [1:0]  last_keep = 2'd0;
    logic [47:0] payload = 48'h3333_2222_1111;
    logic        m_tready = 1'b1;

    logic [15:0] d0_data, d2_data, d0_cnt, d2_cnt;
    logic        d0_vld, d0_last, d0_busy, d0_done;
    logic        d2_vld, d2_last, d2_busy, d2_done;
    logic [1:0]  d0_keep, d2_keep;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_frame_tx #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .frame_len(frame_len),
        .last_keep(last_keep), .payload(payload), .m_tdata(d0_data), .m_tvalid(d0_vld),
        .m_tready(m_tready), .m_tlast(d0_last), .m_tkeep(d0_keep), .busy(d0_busy),
        .frame_done(d0_done), .frame_cnt(d0_cnt)
    );

    axis_frame_tx #(.GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .frame_len(frame_len),
        .last_keep(last_keep), .payload(payload), .m_tdata(d2_data), .m_tvalid(d2_vld),
        .m_tready(m_tready), .m_tlast(d2_last), .m_tkeep(d2_keep), .busy(d2_busy),
        .frame_done(d2_done), .frame_cnt(d2_cnt)
    );

    typedef struct {
        logic        rst_n, en, rdy;
        logic [1:0]  len, keep;
        logic        vld;
        logic [15:0] data;
        logic        last;
        logic [1:0]  tkeep;
        logic        busy, done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(input logic r, e, y, input logic [1:0] l, k, input logic v,
                                input logic [15:0] d, input logic t, input logic [1:0] tk,
                                input logic b, dn, input logic [15:0] c);
        vec_t x;
        x.rst_n = r; x.en = e; x.rdy = y; x.len = l; x.keep = k; x.vld = v;
        x.data = d; x.last = t; x.tkeep = tk; x.busy = b; x.done = dn; x.cnt = c;
        return x;
    endfunction

    function automatic logic [15:0] wd(input int k);
        return 16'(16'h1111 * (k + 1));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int beats, dones;
        //        rst en rdy len keep | vld data      last tkeep busy done cnt
        vt[0]  = mk(0, 0, 1, 3, 0,   0, 16'h0000, 0, 2'b00, 0, 0, 0);
        vt[1]  = mk(1, 1, 1, 3, 0,   1, 16'h1111, 0, 2'b11, 1, 0, 0);
        vt[2]  = mk(1, 0, 1, 3, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 0);
        vt[3]  = mk(1, 0, 1, 3, 0,   1, 16'h3333, 1, 2'b11, 1, 0, 0);
        vt[4]  = mk(1, 0, 1, 3, 0,   0, 16'h0000, 0, 2'b00, 0, 1, 1);
        vt[5]  = mk(1, 0, 1, 3, 0,   0, 16'h0000, 0, 2'b00, 0, 0, 1);
        vt[6]  = mk(1, 1, 1, 3, 0,   1, 16'h1111, 0, 2'b11, 1, 0, 1);
        vt[7]  = mk(1, 0, 1, 3, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 1);
        vt[8]  = mk(1, 0, 0, 3, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 1);
        vt[9]  = mk(1, 0, 0, 3, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 1);
        vt[10] = mk(1, 0, 0, 3, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 1);
        vt[11] = mk(1, 0, 0, 3, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 1);
        vt[12] = mk(1, 0, 1, 3, 0,   1, 16'h3333, 1, 2'b11, 1, 0, 1);
        vt[13] = mk(1, 0, 1, 3, 0,   0, 16'h0000, 0, 2'b00, 0, 1, 2);
        vt[14] = mk(1, 1, 1, 1, 1,   1, 16'h1111, 1, 2'b01, 1, 0, 2);
        vt[15] = mk(1, 0, 1, 1, 1,   0, 16'h0000, 0, 2'b00, 0, 1, 3);
        vt[16] = mk(1, 1, 1, 0, 0,   1, 16'h1111, 0, 2'b11, 1, 0, 3);
        vt[17] = mk(1, 0, 1, 0, 0,   1, 16'h2222, 0, 2'b11, 1, 0, 3);
        vt[18] = mk(1, 0, 1, 0, 0,   1, 16'h3333, 1, 2'b11, 1, 0, 3);
        vt[19] = mk(1, 0, 1, 0, 0,   0, 16'h0000, 0, 2'b00, 0, 1, 4);
        vt[20] = mk(1, 1, 1, 2, 2,   1, 16'h1111, 0, 2'b11, 1, 0, 4);
        vt[21] = mk(1, 0, 1, 2, 2,   1, 16'h2222, 1, 2'b10, 1, 0, 4);
        vt[22] = mk(1, 0, 0, 2, 2,   1, 16'h2222, 1, 2'b10, 1, 0, 4);
        vt[23] = mk(1, 0, 1, 2, 2,   0, 16'h0000, 0, 2'b00, 0, 1, 5);

        #1;
        for (int i = 0; i < 24; i++) begin
            reset_n = vt[i].rst_n; en = vt[i].en; m_tready = vt[i].rdy;
            frame_len = vt[i].len; last_keep = vt[i].keep;
            step();
            chk($sformatf("v%0d tvalid", i), 64'(d0_vld), 64'(vt[i].vld));
            chk($sformatf("v%0d busy", i), 64'(d0_busy), 64'(vt[i].busy));
            chk($sformatf("v%0d frame_done", i), 64'(d0_done), 64'(vt[i].done));
            chk($sformatf("v%0d frame_cnt", i), 64'(d0_cnt), 64'(vt[i].cnt));
            if (vt[i].vld || !vt[i].rst_n) begin
                chk($sformatf("v%0d tdata", i), 64'(d0_data), 64'(vt[i].data));
                chk($sformatf("v%0d tlast", i), 64'(d0_last), 64'(vt[i].last));
                chk($sformatf("v%0d tkeep", i), 64'(d0_keep), 64'(vt[i].tkeep));
            end
        end

        // Continuous mode: dut0 back-to-back, dut2 with two idle cycles between frames.
        reset_n = 1'b0; en = 1'b0; m_tready = 1'b1; step();
        reset_n = 1'b1; mode = 1'b1; en = 1'b1; frame_len = 2'd3; last_keep = 2'd0;
        for (int t = 0; t < 25; t++) begin
            step();
            chk($sformatf("cont0 t%0d tvalid", t), 64'(d0_vld), 64'd1);
            chk($sformatf("cont0 t%0d tdata", t), 64'(d0_data), 64'(wd(t % 3)));
            chk($sformatf("cont0 t%0d tlast", t), 64'(d0_last), 64'(t % 3 == 2));
            chk($sformatf("cont0 t%0d done", t), 64'(d0_done), 64'(t > 0 && t % 3 == 0));
            chk($sformatf("cont0 t%0d cnt", t), 64'(d0_cnt), 64'(t / 3));
            chk($sformatf("gap2 t%0d tvalid", t), 64'(d2_vld), 64'(t % 5 < 3));
            if (t % 5 < 3) chk($sformatf("gap2 t%0d tdata", t), 64'(d2_data), 64'(wd(t % 5)));
            chk($sformatf("gap2 t%0d done", t), 64'(d2_done), 64'(t % 5 == 3));
            chk($sformatf("gap2 t%0d cnt", t), 64'(d2_cnt), 64'((t + 2) / 5));
        end
        en = 1'b0;
        for (int k = 0; k < 10 && (d0_busy || d2_busy); k++) step();
        chk("cont0 idle busy", 64'(d0_busy), 64'd0);
        chk("gap2 idle busy", 64'(d2_busy), 64'd0);
        chk("cont0 final cnt", 64'(d0_cnt), 64'd9);
        chk("gap2 final cnt", 64'(d2_cnt), 64'd5);

        // One-shot with en held: one frame, then HOLD until en falls.
        reset_n = 1'b0; step();
        reset_n = 1'b1; mode = 1'b0; en = 1'b1;
        beats = 0; dones = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (d0_vld) beats++;
            if (d0_done) dones++;
        end
        chk("hold beats", 64'(beats), 64'd3);
        chk("hold dones", 64'(dones), 64'd1);
        chk("hold busy", 64'(d0_busy), 64'd1);
        chk("hold tvalid", 64'(d0_vld), 64'd0);
        chk("hold cnt", 64'(d0_cnt), 64'd1);
        en = 1'b0; step();
        chk("hold release busy", 64'(d0_busy), 64'd0);
        en = 1'b1; step();
        chk("retrigger tvalid", 64'(d0_vld), 64'd1);
        chk("retrigger tdata", 64'(d0_data), 64'h1111);

        // Reset mid-frame while word 1 is on the bus, then restart from word 0.
        en = 1'b0; step();
        chk("mid tdata", 64'(d0_data), 64'h2222);
        reset_n = 1'b0; en = 1'b1; step();
        chk("rst tvalid", 64'(d0_vld), 64'd0);
        chk("rst cnt", 64'(d0_cnt), 64'd0);
        chk("rst done", 64'(d0_done), 64'd0);
        chk("rst busy", 64'(d0_busy), 64'd0);
        reset_n = 1'b1; step();
        chk("restart tvalid", 64'(d0_vld), 64'd1);
        chk("restart tdata", 64'(d0_data), 64'h1111);
        payload = 48'hAAAA_BBBB_CCCC; en = 1'b0; step();
        chk("restart w1", 64'(d0_data), 64'h2222);
        step();
        chk("restart w2", 64'(d0_data), 64'h3333);
        chk("restart tlast", 64'(d0_last), 64'd1);
        step();
        chk("restart done", 64'(d0_done), 64'd1);
        chk("restart cnt", 64'(d0_cnt), 64'd1);
        chk("restart tvalid low", 64'(d0_vld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_frame_tx.md
Name: axis_frame_tx

Overview:
- Parametrised frame transmitter that drives an AXI4-Stream-style master interface (tdata/tvalid/tready/tlast/tkeep) toward the Aurora TX user port.
- On a start request it captures up to N_WORDS payload words and emits a frame of programmable length.
- Supports full tready backpressure, a partial-final-word keep, and one-shot or continuous (repeating, gap-separated) modes, with a frame counter for status.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- N_WORDS, 3, maximum words per frame; must be ≥1.
- GAP_CYCLES, 0, idle cycles between frames in continuous mode; 0 means back-to-back.
- CNT_W, 16, width of frame_cnt.
- Derived: KEEP_W = DATA_W/8; LEN_W = clog2(N_WORDS+1).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- en  in  1  start request, level-sensitive.
- mode  in  1  0 = one-shot, 1 = continuous.
- frame_len  in  LEN_W  words per frame; 0 or >N_WORDS clamps to N_WORDS.
- last_keep  in  KEEP_W  tkeep for the final word; all-zero is treated as all-ones.
- payload  in  N_WORDS*DATA_W  word i at [i*DATA_W +: DATA_W]; word 0 is sent first.
- m_tdata  out  DATA_W  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  final word of frame.
- m_tkeep  out  KEEP_W  byte enables.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_cnt  out  CNT_W  completed-frame count; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; all outputs 0, including frame_cnt. Applies mid-frame too: m_tvalid drops at that edge, the partial frame is abandoned with no tlast, and nothing is resumed.
- All outputs are registered.
- States: IDLE, SEND, GAP, HOLD.
- IDLE, en=1 → capture payload, clamped frame_len, normalised last_keep and mode into internal registers; go to SEND.
  - First m_tvalid appears the cycle after en is sampled (latency 1).
- SEND: m_tvalid=1; m_tdata = captured word[idx], starting at idx=0.
  - Transfer = m_tvalid & m_tready.
  - While m_tvalid & !m_tready, tdata/tkeep/tlast hold stable.
  - m_tkeep is all-ones except on the final word, which carries the captured last_keep.
  - m_tlast=1 only when idx = len-1.
  - Word value never affects m_tvalid; zero words are transmitted.
- On the transfer with tlast, frame_done=1 and frame_cnt+1 on the next cycle, then:
  - captured mode=1, en=1, GAP_CYCLES>0 → GAP (m_tvalid=0) for exactly GAP_CYCLES cycles; then, if en=1, recapture and SEND; otherwise IDLE.
  - captured mode=1, en=1, GAP_CYCLES=0 → recapture on that same edge; m_tvalid stays high with word 0 of the next frame on the following cycle (no bubble).
  - captured mode=0 and en=1 → HOLD. Stay in HOLD while en=1; go to IDLE when en=0. No re-trigger until en has been low for ≥1 cycle.
  - en=0 → IDLE.
- en deasserted mid-frame: the frame completes in full, with no truncation.
- Inputs are ignored outside capture edges. Changing payload or frame_len during SEND does not affect the current frame.
- frame_len=1: a single word carrying tlast and last_keep.
- idx and the gap counter never exceed their bounds. frame_cnt wraps from all-ones to 0 without flagging.

Decomposition:
- Shared package axis_tx_pkg holds:
  - state encoding localparams (IDLE, SEND, GAP, HOLD);
  - MODE_ONESHOT / MODE_CONT constants;
  - a clog2 function.
- One sub-module, frame_word_sel: captured payload register bank plus idx-indexed word mux, parametrised by DATA_W and N_WORDS.
- The FSM, counters and stream outputs stay in axis_frame_tx.

Test Plan:
- Defaults, payload words 0x1111/0x2222/0x3333, frame_len=3, mode=0, en pulsed 1 cycle, tready=1 → three beats on consecutive cycles starting one cycle after en, tlast on the 0x3333 beat, tkeep=2'b11 throughout; frame_done pulses once; frame_cnt=1; state returns to IDLE.
- Same stimulus with tready low for 4 cycles during the 0x2222 beat → 0x2222 holds stable with tvalid=1 and no word is lost or duplicated.
- frame_len=1, last_keep=2'b01 → single beat with data word 0, tlast=1, tkeep=2'b01. frame_len=0 → 3 beats (clamped). last_keep=0 → final tkeep=2'b11.
- mode=1, en held high, GAP_CYCLES=2 → frames separated by exactly 2 tvalid-low cycles. With GAP_CYCLES=0 → tvalid continuous across frames. After 5 frames, frame_cnt=5.
- mode=0, en held high for 20 cycles → exactly one frame, then busy stays high (HOLD) until en falls. A re-assert of en after it falls starts a new frame.
- reset_n low while idx=1 → tvalid=0 at that edge, frame_cnt=0, no frame_done. After release with en=1, a full frame starts from word 0.
